// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 5-9 data bits, none/even/odd parity, 1 or 2 stop bits.
// Optional line-break detection is built when UART_RX_BREAK_EN is defined.
module uart_rx_cfg #(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int N_BITS    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    input  logic              enable,
    output logic [N_BITS-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic              break_det
);
    localparam int CLK_P_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLK_P_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_P_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(CLK_P_BIT / 2);
    localparam logic [3:0]    DATA_LAST = 4'(N_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            state, state_nx;
    logic              sync1, rx_s;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [3:0]        bit_idx, bit_nx;
    logic [N_BITS-1:0] shift, shift_nx;
    logic              perr_acc, perr_nx, ferr_acc, ferr_nx;
    logic              done, brk_nx, start_ok, mid, wrap;

    function automatic logic parity_bad(input logic [N_BITS-1:0] d, input logic bit_in);
        if (PARITY == 1) begin
            return (^d) ^ bit_in;
        end else if (PARITY == 2) begin
            return ~((^d) ^ bit_in);
        end else begin
            return 1'b0;
        end
    endfunction

    assign mid  = (cnt == CNT_MID);
    assign wrap = (cnt == CNT_LAST);

`ifdef UART_RX_BREAK_EN
    logic wait_high, wait_nx, par_zero;

    // Break = all-zero data, zero parity bit, low stop; then lock out until the line is high.
    always_comb begin
        if (PARITY == 1) begin
            par_zero = ~perr_acc;
        end else if (PARITY == 2) begin
            par_zero = perr_acc;
        end else begin
            par_zero = 1'b1;
        end
        brk_nx   = done & (shift_nx == '0) & ferr_nx & par_zero;
        start_ok = ~wait_high;
        if (brk_nx) begin
            wait_nx = 1'b1;
        end else if (rx_s) begin
            wait_nx = 1'b0;
        end else begin
            wait_nx = wait_high;
        end
    end

    // Wait-for-high lockout register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_high <= 1'b0;
        end else begin
            wait_high <= wait_nx;
        end
    end
`else
    // Break detection not built.
    always_comb begin
        brk_nx   = 1'b0;
        start_ok = 1'b1;
    end
`endif

    // Next-state and datapath logic of the receive FSM.
    always_comb begin
        state_nx = state;
        cnt_nx   = wrap ? '0 : cnt + 1'b1;
        bit_nx   = bit_idx;
        shift_nx = shift;
        perr_nx  = perr_acc;
        ferr_nx  = ferr_acc;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                bit_nx = 4'd0;
                if (!rx_s && enable && start_ok) begin
                    state_nx = S_START;
                    perr_nx  = 1'b0;
                    ferr_nx  = 1'b0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_START: begin
                if (mid && rx_s) begin
                    state_nx = S_IDLE;
                end else if (wrap) begin
                    state_nx = S_DATA;
                end else begin
                    state_nx = S_START;
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_nx = {rx_s, shift[N_BITS-1:1]};
                end else begin
                    shift_nx = shift;
                end
                if (wrap && bit_idx == DATA_LAST) begin
                    bit_nx   = 4'd0;
                    state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                end else if (wrap) begin
                    bit_nx = bit_idx + 4'd1;
                end else begin
                    bit_nx = bit_idx;
                end
            end
            S_PARITY: begin
                if (mid) begin
                    perr_nx = parity_bad(shift, rx_s);
                end else begin
                    perr_nx = perr_acc;
                end
                if (wrap) begin
                    state_nx = S_STOP;
                end else begin
                    state_nx = S_PARITY;
                end
            end
            S_STOP: begin
                // Leave at the last stop sample point so a back-to-back start bit is seen.
                if (mid) begin
                    ferr_nx = ferr_acc | ~rx_s;
                    if (bit_idx == STOP_LAST) begin
                        done     = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_STOP;
                    end
                end else if (wrap) begin
                    bit_nx = bit_idx + 4'd1;
                end else begin
                    bit_nx = bit_idx;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Synchroniser, FSM state and frame accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b1;
            rx_s     <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= 4'd0;
            shift    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            sync1    <= rxd;
            rx_s     <= sync1;
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_nx;
            shift    <= shift_nx;
            perr_acc <= perr_nx;
            ferr_acc <= ferr_nx;
        end
    end

    // Registered outputs; word and flags hold until the next completed frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            valid     <= done;
            busy      <= (state_nx != S_IDLE);
            break_det <= brk_nx;
            if (done) begin
                data       <= shift_nx;
                parity_err <= perr_acc;
                frame_err  <= ferr_nx;
            end else begin
                data       <= data;
                parity_err <= parity_err;
                frame_err  <= frame_err;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 10 clocks per bit,
// table-driven frames plus hand sequences, expectations scoreboarded in a queue.
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       reset, enable;
    logic [2:0] rxd;
    logic [7:0] data_o [3];
    logic       valid_o [3];
    logic       perr_o [3];
    logic       ferr_o [3];
    logic       busy_o [3];
    logic       brk_o [3];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic       busy_dis = 1'b0;

    typedef struct {
        int         line;
        logic [7:0] d;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         t_exp;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int         line;
        logic [7:0] d;
        logic       pbit;
        logic [1:0] stops;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;
    vec_t vecs [9];

    uart_rx_cfg #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .N_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .rxd(rxd[0]), .enable(enable), .data(data_o[0]), .valid(valid_o[0]),
        .parity_err(perr_o[0]), .frame_err(ferr_o[0]), .busy(busy_o[0]), .break_det(brk_o[0]));
    uart_rx_cfg #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .N_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .rxd(rxd[1]), .enable(enable), .data(data_o[1]), .valid(valid_o[1]),
        .parity_err(perr_o[1]), .frame_err(ferr_o[1]), .busy(busy_o[1]), .break_det(brk_o[1]));
    uart_rx_cfg #(.CLOCK_HZ(1_000_000), .BAUD_RATE(100_000), .N_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .rxd(rxd[2]), .enable(enable), .data(data_o[2]), .valid(valid_o[2]),
        .parity_err(perr_o[2]), .frame_err(ferr_o[2]), .busy(busy_o[2]), .break_det(brk_o[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!enable && busy_o[0]) busy_dis <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: every valid pops the oldest expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_o[k] === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid line=%0d actual data=%02h required no valid", k, data_o[k]);
                end else begin
                    exp_t e;
                    int   dl;
                    e = sbq.pop_front();
                    chk("valid_line", k, e.line);
                    chk("data", {24'd0, data_o[k]}, {24'd0, e.d});
                    chk("parity_err", {31'd0, perr_o[k]}, {31'd0, e.perr});
                    chk("frame_err", {31'd0, ferr_o[k]}, {31'd0, e.ferr});
                    chk("break_det", {31'd0, brk_o[k]}, {31'd0, e.brk});
                    dl = cyc - e.t_exp;
                    checks++;
                    if (dl < 0 || dl > 1) begin
                        errors++;
                        $display("FAIL latency line=%0d actual=%0d required=%0d..%0d", k, cyc, e.t_exp, e.t_exp + 1);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame on a line (called at a negedge); optional 1-cycle reset pulse at bit rst_bit.
    task automatic send_frame(input int line, input logic [7:0] d, input int pm, input logic pbit,
                              input logic [1:0] stops, input int ns, input int rst_bit,
                              input logic push, input logic [7:0] exp_d, input logic exp_pe,
                              input logic exp_fe, input logic exp_brk);
        logic [15:0] bits;
        int          n;
        exp_t        e;
        bits = 16'hFFFF;
        bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (pm != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < ns; i++) begin
            bits[n] = stops[i];
            n++;
        end
        if (push) begin
            e.line = line; e.d = exp_d; e.perr = exp_pe; e.ferr = exp_fe; e.brk = exp_brk;
            e.t_exp = cyc + 10 * (n - 1) + 8;
            sbq.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            rxd[line] = bits[b];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (b == rst_bit && c == 0) begin
                    reset = 1'b1;
                end
                if (b == rst_bit && c == 1) begin
                    chk("rst_mid_data", {24'd0, data_o[line]}, 32'd0);
                    chk("rst_mid_valid", {31'd0, valid_o[line]}, 32'd0);
                    chk("rst_mid_perr", {31'd0, perr_o[line]}, 32'd0);
                    chk("rst_mid_ferr", {31'd0, ferr_o[line]}, 32'd0);
                    chk("rst_mid_busy", {31'd0, busy_o[line]}, 32'd0);
                    chk("rst_mid_brk", {31'd0, brk_o[line]}, 32'd0);
                    reset = 1'b0;
                end
            end
        end
        rxd[line] = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        rxd    = 3'b111;
        vecs[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{1, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h80, 1'b0, 2'b11, 8'h80, 1'b1, 1'b0};
        vecs[5] = '{2, 8'h3C, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b1};
        vecs[6] = '{2, 8'h11, 1'b0, 2'b11, 8'h11, 1'b0, 1'b0};
        vecs[7] = '{2, 8'hFF, 1'b0, 2'b10, 8'hFF, 1'b0, 1'b1};
        vecs[8] = '{0, 8'h5A, 1'b0, 2'b10, 8'h5A, 1'b0, 1'b1};

        idle(5);
        chk("rst_data", {24'd0, data_o[0]}, 32'd0);
        chk("rst_valid", {31'd0, valid_o[0]}, 32'd0);
        chk("rst_perr", {31'd0, perr_o[0]}, 32'd0);
        chk("rst_ferr", {31'd0, ferr_o[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy_o[0]}, 32'd0);
        chk("rst_brk", {31'd0, brk_o[0]}, 32'd0);
        chk("rst_busy1", {31'd0, busy_o[1]}, 32'd0);
        chk("rst_busy2", {31'd0, busy_o[2]}, 32'd0);
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].line, vecs[i].d, (vecs[i].line == 1) ? 1 : 0, vecs[i].pbit,
                       vecs[i].stops, (vecs[i].line == 2) ? 2 : 1, -1, 1'b1,
                       vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe, 1'b0);
            idle(20);
            chk("busy_after_frame", {31'd0, busy_o[vecs[i].line]}, 32'd0);
        end

        // False start: 3-cycle low glitch, no valid, data unchanged.
        rxd[0] = 1'b0;
        idle(3);
        rxd[0] = 1'b1;
        idle(20);
        chk("false_start_busy", {31'd0, busy_o[0]}, 32'd0);
        chk("false_start_data", {24'd0, data_o[0]}, 32'h5A);

        // Back-to-back frames with one stop bit.
        send_frame(0, 8'h55, 0, 1'b0, 2'b11, 1, -1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hAA, 0, 1'b0, 2'b11, 1, -1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        idle(20);

        // Frame while disabled is ignored.
        enable = 1'b0;
        send_frame(0, 8'h42, 0, 1'b0, 2'b11, 1, -1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(20);
        enable = 1'b1;
        chk("busy_while_disabled", {31'd0, busy_dis}, 32'd0);
        chk("data_after_disabled", {24'd0, data_o[0]}, 32'hAA);

        // Reset pulse during the last data bit discards the frame.
        send_frame(0, 8'h99, 0, 1'b0, 2'b11, 1, 8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(20);
        send_frame(0, 8'h12, 0, 1'b0, 2'b11, 1, -1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        idle(20);

`ifdef UART_RX_BREAK_EN
        begin
            exp_t e;
            e.line = 0; e.d = 8'h00; e.perr = 1'b0; e.ferr = 1'b1; e.brk = 1'b1;
            e.t_exp = cyc + 98;
            sbq.push_back(e);
            rxd[0] = 1'b0;
            idle(200);
            chk("break_idle_busy", {31'd0, busy_o[0]}, 32'd0);
            rxd[0] = 1'b1;
            idle(20);
            send_frame(0, 8'h01, 0, 1'b0, 2'b11, 1, -1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
            idle(20);
        end
`endif

        chk("pending_expectations", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
